// File: rtl/uart_byte_rx.sv
`timescale 1ns/1ps
// Purpose: 8N1 UART receiver. It synchronises the pin, validates the start bit at mid-bit and samples the data bits at mid-bit.
// Latency: the byte appears 2 + HALF + 9*CLKS_PER_BIT (+1) clocks after the falling edge of the start bit on the pin.
// Backpressure: there is a single-entry valid/ready holding register; a new good byte that arrives while it is full is dropped and overrun pulses.
// Ports: clk, rst (sync, active-high), uart_rx (async serial in, idles high), rx_data/rx_valid/rx_ready (byte handshake),
//        busy (FSM not idle), frame_err (1-clk pulse, stop bit low), overrun (1-clk pulse, good byte dropped).
module uart_byte_rx #(
   parameter int CLK_HZ = 12_000_000,
   parameter int BAUD   = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun
);

   // CLKS_PER_BIT must be at least 4 so that HALF-1 and CLKS_PER_BIT-1 are distinct, non-zero counts.
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int HALF         = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t           state, state_n;
   logic             sync_ff1, rx_sync;
   logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shift_reg, shift_n;
   logic             stop_ok, stop_bad;
   logic             load, drop;

   // Two-flop synchroniser. It resets to the idle (high) level so that reset itself never looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_ff1 <= 1'b1;
         rx_sync  <= 1'b1;
      end else begin
         sync_ff1 <= uart_rx;
         rx_sync  <= sync_ff1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         state     <= state_n;
         clk_cnt   <= clk_cnt_n;
         bit_idx   <= bit_idx_n;
         shift_reg <= shift_n;
      end
   end

   always_comb begin
      state_n   = state;
      clk_cnt_n = clk_cnt + CNT_ONE;
      bit_idx_n = bit_idx;
      shift_n   = shift_reg;
      stop_ok   = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         S_IDLE: begin
            clk_cnt_n = '0;
            if (!rx_sync) state_n = S_START;
         end
         S_START: begin
            // Re-check the line half a bit in. If it is high again, the low was a glitch and nothing is reported.
            if (clk_cnt == CNT_HALF) begin
               clk_cnt_n = '0;
               bit_idx_n = '0;
               state_n   = rx_sync ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (clk_cnt == CNT_LAST) begin
               clk_cnt_n = '0;
               shift_n   = {rx_sync, shift_reg[7:1]};   // LSB arrives first
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = S_STOP;
            end
         end
         S_STOP: begin
            // Leave at mid-stop-bit so that a start bit immediately following it is not missed.
            if (clk_cnt == CNT_LAST) begin
               clk_cnt_n = '0;
               if (rx_sync) begin
                  stop_ok = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  stop_bad = 1'b1;
                  state_n  = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            // A break or a line stuck low must not be taken as a string of start bits.
            clk_cnt_n = '0;
            if (rx_sync) state_n = S_IDLE;
         end
         default: begin
            clk_cnt_n = '0;
            state_n   = S_IDLE;
         end
      endcase
   end

   // A byte can be loaded on the same edge that the previous byte is consumed.
   assign load = stop_ok && (!rx_valid || rx_ready);
   assign drop = stop_ok && rx_valid && !rx_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) begin
            rx_data  <= shift_reg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         // stop_ok and stop_bad are exclusive, so these pulses can never coincide.
         frame_err <= stop_bad;
         overrun   <= drop;
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

UART receiver that turns the asynchronous `uart_rx` pin into bytes for the mirror/echo logic. It sits directly upstream of the byte-handling and transmit path. It synchronises the pin and validates the start bit. It samples 8N1 frames at mid-bit and presents each byte on a single-entry valid/ready holding register, with framing and overrun indications.

## Interface
- `CLK_HZ`, 12_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line rate; `CLKS_PER_BIT = CLK_HZ/BAUD` (1250 at defaults), integer division; must be ≥ 4.
- `clk` input 1 system clock; all logic on the rising edge.
- `rst` input 1 synchronous, active-high reset.
- `uart_rx` input 1 asynchronous serial line; idles high.
- `rx_data` output 8 received byte; valid while `rx_valid`=1.
- `rx_valid` output 1 holding register contains an unconsumed byte.
- `rx_ready` input 1 consumer accepts `rx_data` when `rx_valid`&`rx_ready` at a clock edge.
- `busy` output 1 high whenever the FSM is not in IDLE.
- `frame_err` output 1 one-cycle pulse: stop bit sampled low.
- `overrun` output 1 one-cycle pulse: a good byte was dropped because the holding register was full.

## Operation
- Input path: 2-FF synchroniser `uart_rx` -> `rx_sync`. Both FFs reset to 1. FSM acts only on `rx_sync`.
- Counters: `clk_cnt` counts 0..CLKS_PER_BIT-1 and is sized by `$clog2(CLKS_PER_BIT)`. `bit_idx` is 3 bits. `HALF = CLKS_PER_BIT/2` (625).
- States:
  - IDLE: when `rx_sync`=0, go to START with `clk_cnt`=0.
  - START: on reaching `clk_cnt`=HALF-1, re-check `rx_sync`. If it is 0, go to DATA with `clk_cnt`=0 and `bit_idx`=0. If it is 1, the low was a glitch: go to IDLE with no outputs.
  - DATA: on reaching `clk_cnt`=CLKS_PER_BIT-1, shift `rx_sync` into the shift register LSB-first and reset `clk_cnt`. After the bit with `bit_idx`=7, go to STOP.
  - STOP: on reaching `clk_cnt`=CLKS_PER_BIT-1, sample `rx_sync`.
    - Sample 1: deliver the byte (rules below) and go to IDLE immediately, at mid-stop-bit, so back-to-back frames are caught.
    - Sample 0: pulse `frame_err`, discard the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_sync`=1, then go to IDLE. This covers break conditions and line held low.
- Holding register, evaluated on the same edge as the STOP sample:
  - `rx_valid`=0, or `rx_valid`=1 with `rx_ready`=1 in that cycle: load `rx_data` and set `rx_valid`=1. No overrun.
  - `rx_valid`=1 with `rx_ready`=0: keep the old `rx_data`, drop the new byte, pulse `overrun`.
  - Otherwise `rx_valid` clears on the edge where `rx_valid`&`rx_ready`.
- `rx_data` changes only on load; it holds its value after consumption.
- `frame_err` and `overrun` are never asserted in the same cycle.
- Reset at any time: FSM goes to IDLE and all counters clear, discarding any partial frame.
  - Outputs `rx_data`=0x00, `rx_valid`=0, `busy`=0, `frame_err`=0, `overrun`=0. Synchroniser = 1.
  - After reset is released, a line that is already low is treated as a start edge.

## Timing
- Synchroniser latency is 2 clocks.
- START check: HALF clocks after `rx_sync` falls, which is 627 clocks after the pin edge.
- Data bit n is sampled at 2 + HALF + (n+1)·CLKS_PER_BIT clocks after the pin falling edge (±1).
- The stop sample, and the `rx_valid` rise (or `frame_err`/`overrun` pulse), occur at 2 + HALF + 9·CLKS_PER_BIT = 11877 clocks after the pin falling edge at defaults, ±1.
- `busy` rises 1 clock after `rx_sync` falls. It falls on the edge the FSM re-enters IDLE.
- Pulse width of `frame_err`/`overrun` is exactly 1 clock.
- The handshake has no combinational path from `rx_ready` to any output.
- Tolerated baud mismatch is about ±4% (mid-bit sampling).

## Test plan
- Reset: hold `rst`=1 for 5 clocks with `uart_rx`=1. Required: all outputs 0, `rx_data`=0x00, and they stay 0 for 20k clocks of idle line.
- Single byte: send 0x0D at defaults (84 ns clock, 104 µs bits), with `rx_ready`=0.
  - `rx_valid` rises 11877±2 clocks after the start edge with `rx_data`=0x0D, and stays high.
  - Pulsing `rx_ready` for 1 clock clears `rx_valid` on the next edge; `rx_data` remains 0x0D.
- Back-to-back overrun: send 0x0D then 0x0A with no gap, `rx_ready`=0.
  - `rx_valid`=1 with `rx_data`=0x0D; at the second stop sample, `overrun` pulses for 1 clock and `rx_data` stays 0x0D.
  - Repeat with `rx_ready`=1 held throughout: both bytes are delivered in order and `overrun` never asserts.
- Glitch: drive `uart_rx` low for 200 clocks, then high. Required: no `rx_valid`, no `frame_err`, and `busy` low again within 630 clocks.
- Framing error: send 0x55 with the stop bit low and the line held low for 3 further bit times.
  - `frame_err` pulses once, `rx_valid` stays 0, and `busy` stays high until 2 clocks after the line returns high.
  - A following 0x0A is then received correctly.
- Mid-frame reset: assert `rst` for 1 clock during data bit 4 of 0x0D. Required: no byte is delivered and `busy`=0 after reset; the next full 0x0A frame yields `rx_data`=0x0A.
